// File: rtl/fir_stream_addrgen.sv
// Streamer address generator: accepts one 1D/2D/3D job and emits its word-address
// sequence on a valid/ready stream, then pulses done_o for one cycle.
module fir_stream_addrgen #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned STRIDE_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    req_start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    tot_len_i,
    input  logic [LEN_WIDTH-1:0]    d0_len_i,
    input  logic [STRIDE_WIDTH-1:0] d0_stride_i,
    input  logic [LEN_WIDTH-1:0]    d1_len_i,
    input  logic [STRIDE_WIDTH-1:0] d1_stride_i,
    input  logic [STRIDE_WIDTH-1:0] d2_stride_i,
    input  logic [1:0]              dim_enable_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic                    ready_start_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] Dim1 = 2'b00;
    localparam logic [1:0] Dim2 = 2'b01;
    localparam logic [1:0] Dim3 = 2'b11;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] plane_base_q, plane_base_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]  d0_cnt_q, d0_cnt_d;
    logic [LEN_WIDTH-1:0]  d1_cnt_q, d1_cnt_d;
    // Last-index values (len-1) so wrap checks are a plain compare; len 0 acts as 1.
    logic [LEN_WIDTH-1:0]  tot_last_q, tot_last_d;
    logic [LEN_WIDTH-1:0]  d0_last_q, d0_last_d;
    logic [LEN_WIDTH-1:0]  d1_last_q, d1_last_d;
    logic [ADDR_WIDTH-1:0] d0_stride_q, d0_stride_d;
    logic [ADDR_WIDTH-1:0] d1_stride_q, d1_stride_d;
    logic [ADDR_WIDTH-1:0] d2_stride_q, d2_stride_d;
    logic [1:0]            dim_q, dim_d;

    logic [ADDR_WIDTH-1:0] next_line;
    logic [ADDR_WIDTH-1:0] next_plane;
    logic                  last_beat;
    logic                  d0_wrap;
    logic                  d1_wrap;

    assign next_line  = line_base_q + d1_stride_q;
    assign next_plane = plane_base_q + d2_stride_q;
    assign last_beat  = (beat_cnt_q == tot_last_q);
    assign d0_wrap    = (d0_cnt_q == d0_last_q);
    assign d1_wrap    = (d1_cnt_q == d1_last_q);

    // Next-state: job latch in idle, address walk on each handshake, soft clear on top.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_base_d  = line_base_q;
        plane_base_d = plane_base_q;
        beat_cnt_d   = beat_cnt_q;
        d0_cnt_d     = d0_cnt_q;
        d1_cnt_d     = d1_cnt_q;
        tot_last_d   = tot_last_q;
        d0_last_d    = d0_last_q;
        d1_last_d    = d1_last_q;
        d0_stride_d  = d0_stride_q;
        d1_stride_d  = d1_stride_q;
        d2_stride_d  = d2_stride_q;
        dim_d        = dim_q;

        unique case (state_q)
            StIdle: begin
                if (req_start_i) begin
                    tot_last_d   = tot_len_i - LEN_WIDTH'(1);
                    d0_last_d    = (d0_len_i == '0) ? '0 : d0_len_i - LEN_WIDTH'(1);
                    d1_last_d    = (d1_len_i == '0) ? '0 : d1_len_i - LEN_WIDTH'(1);
                    d0_stride_d  = ADDR_WIDTH'(d0_stride_i);
                    d1_stride_d  = ADDR_WIDTH'(d1_stride_i);
                    d2_stride_d  = ADDR_WIDTH'(d2_stride_i);
                    // 2'b10 is not a legal mode and falls back to 1D.
                    dim_d        = (dim_enable_i == 2'b10) ? Dim1 : dim_enable_i;
                    addr_d       = base_addr_i;
                    line_base_d  = base_addr_i;
                    plane_base_d = base_addr_i;
                    beat_cnt_d   = '0;
                    d0_cnt_d     = '0;
                    d1_cnt_d     = '0;
                    state_d      = (tot_len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (addr_ready_i) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = StDone;
                    end
                    if (dim_q == Dim1) begin
                        addr_d = addr_q + d0_stride_q;
                    end else if (d0_wrap) begin
                        d0_cnt_d = '0;
                        if (dim_q == Dim3 && d1_wrap) begin
                            d1_cnt_d     = '0;
                            plane_base_d = next_plane;
                            line_base_d  = next_plane;
                            addr_d       = next_plane;
                        end else begin
                            if (dim_q == Dim3) begin
                                d1_cnt_d = d1_cnt_q + LEN_WIDTH'(1);
                            end
                            line_base_d = next_line;
                            addr_d      = next_line;
                        end
                    end else begin
                        d0_cnt_d = d0_cnt_q + LEN_WIDTH'(1);
                        addr_d   = addr_q + d0_stride_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear_i) begin
            state_d    = StIdle;
            addr_d     = '0;
            beat_cnt_d = '0;
            d0_cnt_d   = '0;
            d1_cnt_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            line_base_q  <= '0;
            plane_base_q <= '0;
            beat_cnt_q   <= '0;
            d0_cnt_q     <= '0;
            d1_cnt_q     <= '0;
            tot_last_q   <= '0;
            d0_last_q    <= '0;
            d1_last_q    <= '0;
            d0_stride_q  <= '0;
            d1_stride_q  <= '0;
            d2_stride_q  <= '0;
            dim_q        <= Dim1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_base_q  <= line_base_d;
            plane_base_q <= plane_base_d;
            beat_cnt_q   <= beat_cnt_d;
            d0_cnt_q     <= d0_cnt_d;
            d1_cnt_q     <= d1_cnt_d;
            tot_last_q   <= tot_last_d;
            d0_last_q    <= d0_last_d;
            d1_last_q    <= d1_last_d;
            d0_stride_q  <= d0_stride_d;
            d1_stride_q  <= d1_stride_d;
            d2_stride_q  <= d2_stride_d;
            dim_q        <= dim_d;
        end
    end

    // Outputs decode straight from registered state; valid never depends on ready.
    always_comb begin
        addr_o        = addr_q;
        addr_valid_o  = (state_q == StRun);
        ready_start_o = (state_q == StIdle);
        busy_o        = (state_q == StRun) || (state_q == StDone);
        done_o        = (state_q == StDone);
    end

endmodule
